// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow clock-like signal in clk_in cycles,
// with a sticky timeout when the signal stops toggling.
module clock_period_meter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             new_sample,
    output logic             timeout,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           state;
    logic             sync1;
    logic             synced;
    logic             prev;
    logic [1:0]       flushed;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hcap;
    logic             rise;
    logic             fall;

    assign rise      = synced & ~prev;
    assign fall      = ~synced & prev;
    assign state_dbg = state;

    // valid qualifies period/high_time; new_sample pulses for the single cycle
    // in which they take a new value. There is no back-pressure.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= ARM;
            sync1      <= 1'b0;
            synced     <= 1'b0;
            prev       <= 1'b0;
            flushed    <= 2'b00;
            cnt        <= '0;
            hcap       <= '0;
            period     <= '0;
            high_time  <= '0;
            valid      <= 1'b0;
            new_sample <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            sync1      <= sig_in;
            synced     <= sync1;
            prev       <= synced;
            flushed    <= {flushed[0], 1'b1};
            new_sample <= 1'b0;
            case (state)
                // The synchroniser holds reset zeros for two cycles; arming on
                // those would fake a low phase when sig_in is high at release.
                ARM: begin
                    if (flushed[1] && !synced) begin
                        state <= FIRST;
                    end
                end
                FIRST: begin
                    if (rise) begin
                        cnt   <= ONE;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hcap;
                        valid      <= 1'b1;
                        timeout    <= 1'b0;
                        new_sample <= 1'b1;
                        cnt        <= ONE;
                    end else if (cnt == TIMEOUT_V) begin
                        timeout <= 1'b1;
                        valid   <= 1'b0;
                        state   <= ARM;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                    if (fall) begin
                        hcap <= cnt;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: table of steady waveforms plus
// hand-written reset, arming and timeout sequences.
module tb_clock_period_meter;

    localparam int W  = 16;
    localparam int TO = 100;

    logic         clk_in = 1'b0;
    logic         reset  = 1'b1;
    logic         sig_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         new_sample;
    logic         timeout;
    logic [1:0]   state_dbg;

    clock_period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .valid      (valid),
        .new_sample (new_sample),
        .timeout    (timeout),
        .state_dbg  (state_dbg)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int lo;
        int hi;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    logic [2*W-1:0] exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_ns  = 0;
    logic prev_ns  = 1'b0;
    logic last_s   = 1'b0;
    int   hi_run   = 0;
    int   lo_run   = 0;
    bit   armed    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clk_in cycle: update the waveform model, drive, then sample #1 after the edge.
    task automatic step(input logic s);
        logic [2*W-1:0] e;
        if (s && !last_s && !reset) begin
            if (armed) exp_q.push_back({W'(hi_run + lo_run), W'(hi_run)});
            armed  = 1'b1;
            hi_run = 0;
            lo_run = 0;
        end
        if (s) hi_run++;
        else   lo_run++;
        last_s = s;
        sig_in = s;
        @(posedge clk_in);
        #1;
        cyc++;
        if (new_sample) begin
            last_ns = cyc;
            check("ns_not_back_to_back", 32'(prev_ns), 32'd0);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_sample: got period %0d high_time %0d, expected no sample",
                         period, high_time);
            end else begin
                e = exp_q.pop_front();
                if (period !== e[2*W-1:W] || high_time !== e[W-1:0]) begin
                    n_fail++;
                    $display("FAIL sample: got period %0d high_time %0d, expected %0d/%0d",
                             period, high_time, e[2*W-1:W], e[W-1:0]);
                end
            end
        end
        prev_ns = new_sample;
    endtask

    task automatic do_reset(input logic lvl, input int ncyc);
        reset = 1'b1;
        armed = 1'b0;
        repeat (ncyc) step(lvl);
        check("rst_period", 32'(period), 32'd0);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_new_sample", 32'(new_sample), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset  = 1'b0;
        armed  = 1'b0;
        last_s = lvl;
        hi_run = 0;
        lo_run = 0;
        prev_ns = 1'b0;
        exp_q.delete();
    endtask

    task automatic wave(input int lo, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            repeat (lo) step(1'b0);
            repeat (hi) step(1'b1);
        end
    endtask

    task automatic settle_and_check(input string name, input int exp_p, input int exp_h);
        repeat (4) step(1'b0);
        check({name, "_period"}, 32'(period), 32'(exp_p));
        check({name, "_high_time"}, 32'(high_time), 32'(exp_h));
        check({name, "_valid"}, 32'(valid), 32'd1);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        int   to_cyc;
        bit   seen;
        logic v_prev;

        vecs[0] = '{lo: 12, hi: 13, n: 6,  exp_p: 25, exp_h: 13};
        vecs[1] = '{lo: 3,  hi: 5,  n: 6,  exp_p: 8,  exp_h: 5};
        vecs[2] = '{lo: 1,  hi: 1,  n: 10, exp_p: 2,  exp_h: 1};
        vecs[3] = '{lo: 7,  hi: 2,  n: 5,  exp_p: 9,  exp_h: 2};

        // Divide-by-25 start: the first rise only arms the meter.
        do_reset(1'b0, 2);
        wave(12, 13, 1);
        check("first_rise_valid", 32'(valid), 32'd0);
        check("first_rise_state", 32'(state_dbg), 32'd2);
        for (int i = 0; i < 4; i++) begin
            wave(vecs[i].lo, vecs[i].hi, vecs[i].n);
            settle_and_check($sformatf("vec%0d", i), vecs[i].exp_p, vecs[i].exp_h);
        end

        // High through reset release: must stay armed-waiting until a real low.
        do_reset(1'b1, 2);
        repeat (6) step(1'b1);
        check("held_high_state", 32'(state_dbg), 32'd0);
        check("held_high_valid", 32'(valid), 32'd0);
        wave(5, 5, 4);
        settle_and_check("held_high", 10, 5);

        // Timeout after the signal stops, then recovery.
        do_reset(1'b0, 2);
        wave(10, 10, 4);
        seen   = 1'b0;
        to_cyc = 0;
        v_prev = 1'b0;
        for (int i = 0; i < 200; i++) begin
            v_prev = valid;
            step(1'b0);
            if (timeout) begin
                seen   = 1'b1;
                to_cyc = cyc;
                break;
            end
        end
        check("timeout_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("timeout_latency", 32'(to_cyc - last_ns), 32'(TO));
            check("valid_before_timeout", 32'(v_prev), 32'd1);
            check("timeout_valid", 32'(valid), 32'd0);
            check("timeout_period_kept", 32'(period), 32'd20);
            check("timeout_high_kept", 32'(high_time), 32'd10);
        end
        armed = 1'b0;
        wave(10, 10, 1);
        check("resume_first_rise_timeout", 32'(timeout), 32'd1);
        check("resume_first_rise_valid", 32'(valid), 32'd0);
        wave(10, 10, 2);
        check("resume_timeout_cleared", 32'(timeout), 32'd0);
        settle_and_check("resume", 20, 10);

        // One-cycle reset in the middle of a high phase.
        do_reset(1'b0, 2);
        wave(6, 6, 3);
        check("queue_before_reset", 32'(exp_q.size()), 32'd0);
        do_reset(1'b1, 1);
        repeat (3) step(1'b1);
        wave(6, 6, 4);
        settle_and_check("after_mid_reset", 12, 6);

        // No toggling at all: timeout is never checked outside RUN.
        do_reset(1'b0, 2);
        repeat (150) step(1'b0);
        check("idle_timeout", 32'(timeout), 32'd0);
        check("idle_valid", 32'(valid), 32'd0);
        check("idle_state", 32'(state_dbg), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
